// File: rtl/mem_rr_arbiter_pkg.sv
// Shared types and constants for the memory round-robin arbiter.
// Tags carry the requester id of each outstanding request plus a flush-kill bit.
package mem_rr_arbiter_pkg;
  localparam int TAG_ID_W = 4;  // supports up to 16 requesters
  localparam int REQ_IF   = 0;
  localparam int REQ_LSU  = 1;

  typedef logic [TAG_ID_W-1:0] mem_req_id_t;

  typedef struct packed {
    mem_req_id_t id;
    logic        kill;
  } mem_tag_t;

  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction
endpackage

// File: rtl/mem_rr_arbiter_tag_fifo.sv
// Sync FIFO of response tags with occupancy count and a kill-all input that
// marks every stored entry (and a same-cycle push) as killed.
module mem_tag_fifo
  import mem_rr_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  mem_tag_t         push_tag,
  input  logic             pop,
  input  logic             flush,
  output mem_tag_t         head,
  output logic [CNT_W-1:0] cnt,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  mem_tag_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;

  function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (cnt == CNT_W'(DEPTH));
  assign empty = (cnt == '0);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      // Stale slots get killed too; they are overwritten before they are read.
      if (flush)
        for (int i = 0; i < DEPTH; i++) mem[i].kill <= 1'b1;
      if (push) begin
        mem[wr_ptr] <= '{id: push_tag.id, kill: push_tag.kill | flush};
        wr_ptr      <= inc(wr_ptr);
      end
      if (pop) rd_ptr <= inc(rd_ptr);
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin, grant-locked arbiter sharing one memory req/resp channel among
// NUM_REQ requesters; responses are routed in order via a tag FIFO.
module mem_rr_arbiter
  import mem_rr_arbiter_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]              resp_valid,
  input  logic [NUM_REQ-1:0]              resp_ready,
  output logic [DATA_W-1:0]               resp_data,
  output logic                            mem_req_valid,
  input  logic                            mem_req_ready,
  output logic [DATA_W-1:0]               mem_req_data,
  input  logic                            mem_resp_valid,
  output logic                            mem_resp_ready,
  input  logic [DATA_W-1:0]               mem_resp_data
);
  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [ID_W-1:0]  rr_ptr, grant_q, grant, pick;
  logic             lock;
  logic [CNT_W-1:0] cnt;
  logic             full, empty, mem_req_fire, mem_resp_fire;
  mem_tag_t         head, push_tag;

  // Scan downward so the lowest offset from rr_ptr wins.
  always_comb begin
    int idx;
    idx  = 0;
    pick = rr_ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (req_valid[idx]) pick = ID_W'(idx);
    end
  end

  assign grant = lock ? grant_q : pick;

  // Request side is combinational off the inputs, so gate it with reset directly.
  assign mem_req_valid = rst_n && req_valid[grant] && !full;
  assign mem_req_data  = req_data[grant];
  assign mem_req_fire  = mem_req_valid && mem_req_ready;

  always_comb begin
    req_ready        = '0;
    req_ready[grant] = rst_n && mem_req_ready && !full;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr  <= '0;
      grant_q <= '0;
      lock    <= 1'b0;
    end else if (mem_req_fire) begin
      rr_ptr <= ID_W'(wrap_inc(int'(grant), NUM_REQ));
      lock   <= 1'b0;
    end else if (mem_req_valid && !mem_req_ready) begin
      lock    <= 1'b1;
      grant_q <= grant;
    end
  end

  assign push_tag      = '{id: TAG_ID_W'(grant), kill: flush};
  assign mem_resp_fire = mem_resp_valid && mem_resp_ready;

  mem_tag_fifo #(.DEPTH(MAX_OUTSTANDING)) u_tags (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (mem_req_fire),
    .push_tag (push_tag),
    .pop      (mem_resp_fire),
    .flush    (flush),
    .head     (head),
    .cnt      (cnt),
    .full     (full),
    .empty    (empty)
  );

  // Killed heads are drained unconditionally so memory never stalls on them.
  always_comb begin
    resp_valid     = '0;
    mem_resp_ready = 1'b0;
    if (!empty) begin
      if (head.kill) begin
        mem_resp_ready = 1'b1;
      end else begin
        resp_valid[head.id[ID_W-1:0]] = mem_resp_valid;
        mem_resp_ready                = resp_ready[head.id[ID_W-1:0]];
      end
    end
  end

  assign resp_data = mem_resp_data;
endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed bench for mem_rr_arbiter: per-cycle vector table plus hand sequences
// for flush interactions and reset in the middle of a transaction.
module tb_mem_rr_arbiter;
  import mem_rr_arbiter_pkg::*;

  logic              clk, rst_n, flush;
  logic [1:0]        req_valid, req_ready, resp_valid, resp_ready;
  logic [1:0][31:0]  req_data;
  logic [31:0]       resp_data, mem_req_data, mem_resp_data;
  logic              mem_req_valid, mem_req_ready, mem_resp_valid, mem_resp_ready;

  int n_chk = 0, n_fail = 0;
  logic stall_prev = 1'b0;
  logic g_prev = 1'b0;

  mem_rr_arbiter #(.NUM_REQ(2), .DATA_W(32), .MAX_OUTSTANDING(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_data(mem_req_data),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_resp_data(mem_resp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  rv;   logic mr; logic mv; logic [31:0] md; logic [1:0] rrdy; logic fl;
    logic        emv;  logic [1:0] erdy; logic egr; logic [1:0] erv; logic emrr; int ecnt;
  } vec_t;
  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs at negedge; also checks the two protocol rules.
  task automatic step(input logic [1:0] rv, input logic mr, input logic mv,
                      input logic [31:0] md, input logic [1:0] rrdy, input logic fl);
    @(negedge clk);
    req_valid = rv; mem_req_ready = mr; mem_resp_valid = mv;
    mem_resp_data = md; resp_ready = rrdy; flush = fl;
    #1;
    if (stall_prev) chk("locked req_valid held", {31'b0, req_valid[g_prev]}, 32'd1);
    if (mem_resp_valid) chk("mem_resp_valid only when nonempty", {31'b0, dut.cnt != 0}, 32'd1);
    stall_prev = mem_req_valid && !mem_req_ready;
    g_prev     = dut.grant;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    req_data[REQ_IF] = 32'h100; req_data[REQ_LSU] = 32'h200;
    req_valid = 2'b11; mem_req_ready = 1'b1; mem_resp_valid = 1'b0;
    mem_resp_data = '0; resp_ready = 2'b11;
    #12;
    chk("reset req_ready", {30'b0, req_ready}, 32'd0);
    chk("reset mem_req_valid", {31'b0, mem_req_valid}, 32'd0);
    chk("reset resp_valid", {30'b0, resp_valid}, 32'd0);
    chk("reset mem_resp_ready", {31'b0, mem_resp_ready}, 32'd0);
    chk("reset cnt", 32'(dut.cnt), 32'd0);
    @(negedge clk); rst_n = 1'b1; req_valid = 2'b00;

    //                rv    mr    mv    md           rrdy  fl    emv   erdy  egr   erv   emrr  cnt
    vt.push_back('{2'b00,1'b1,1'b0,32'h0,   2'b11,1'b0, 1'b0,2'b01,1'b0,2'b00,1'b0,0}); // single IF
    vt.push_back('{2'b01,1'b1,1'b0,32'h0,   2'b11,1'b0, 1'b1,2'b01,1'b0,2'b00,1'b0,0});
    vt.push_back('{2'b00,1'b1,1'b0,32'h0,   2'b11,1'b0, 1'b0,2'b10,1'b0,2'b00,1'b1,1});
    vt.push_back('{2'b00,1'b1,1'b0,32'h0,   2'b11,1'b0, 1'b0,2'b10,1'b0,2'b00,1'b1,1});
    vt.push_back('{2'b00,1'b1,1'b1,32'hDEAD,2'b11,1'b0, 1'b0,2'b10,1'b0,2'b01,1'b1,1});
    vt.push_back('{2'b00,1'b1,1'b0,32'h0,   2'b11,1'b0, 1'b0,2'b10,1'b0,2'b00,1'b0,0});
    vt.push_back('{2'b11,1'b1,1'b0,32'h0,   2'b11,1'b0, 1'b1,2'b10,1'b1,2'b00,1'b0,0}); // contention
    vt.push_back('{2'b11,1'b1,1'b0,32'h0,   2'b11,1'b0, 1'b1,2'b01,1'b0,2'b00,1'b1,1});
    vt.push_back('{2'b11,1'b1,1'b1,32'hA1,  2'b11,1'b0, 1'b1,2'b10,1'b1,2'b10,1'b1,2});
    vt.push_back('{2'b00,1'b1,1'b1,32'hB0,  2'b10,1'b0, 1'b0,2'b01,1'b0,2'b01,1'b0,2}); // resp backpressure
    vt.push_back('{2'b00,1'b1,1'b1,32'hB0,  2'b11,1'b0, 1'b0,2'b01,1'b0,2'b01,1'b1,2});
    vt.push_back('{2'b00,1'b1,1'b1,32'hC1,  2'b11,1'b0, 1'b0,2'b01,1'b0,2'b10,1'b1,1});
    vt.push_back('{2'b10,1'b0,1'b0,32'h0,   2'b11,1'b0, 1'b1,2'b00,1'b1,2'b00,1'b0,0}); // lock on 1
    vt.push_back('{2'b11,1'b0,1'b0,32'h0,   2'b11,1'b0, 1'b1,2'b00,1'b1,2'b00,1'b0,0});
    vt.push_back('{2'b11,1'b0,1'b0,32'h0,   2'b11,1'b0, 1'b1,2'b00,1'b1,2'b00,1'b0,0});
    vt.push_back('{2'b11,1'b0,1'b0,32'h0,   2'b11,1'b0, 1'b1,2'b00,1'b1,2'b00,1'b0,0});
    vt.push_back('{2'b11,1'b1,1'b0,32'h0,   2'b11,1'b0, 1'b1,2'b10,1'b1,2'b00,1'b0,0});
    vt.push_back('{2'b11,1'b1,1'b0,32'h0,   2'b11,1'b0, 1'b1,2'b01,1'b0,2'b00,1'b1,1});
    vt.push_back('{2'b11,1'b1,1'b0,32'h0,   2'b11,1'b0, 1'b1,2'b10,1'b1,2'b00,1'b1,2}); // fill up
    vt.push_back('{2'b11,1'b1,1'b0,32'h0,   2'b11,1'b0, 1'b1,2'b01,1'b0,2'b00,1'b1,3});
    vt.push_back('{2'b11,1'b1,1'b0,32'h0,   2'b11,1'b0, 1'b0,2'b00,1'b1,2'b00,1'b1,4});
    vt.push_back('{2'b11,1'b1,1'b1,32'hD1,  2'b11,1'b0, 1'b0,2'b00,1'b1,2'b10,1'b1,4});
    vt.push_back('{2'b11,1'b1,1'b1,32'hE0,  2'b11,1'b0, 1'b1,2'b10,1'b1,2'b01,1'b1,3}); // push+pop
    vt.push_back('{2'b11,1'b1,1'b0,32'h0,   2'b11,1'b0, 1'b1,2'b01,1'b0,2'b00,1'b1,3});
    vt.push_back('{2'b00,1'b1,1'b0,32'h0,   2'b11,1'b0, 1'b0,2'b00,1'b1,2'b00,1'b1,4});
    vt.push_back('{2'b00,1'b1,1'b1,32'hF1,  2'b11,1'b0, 1'b0,2'b00,1'b1,2'b10,1'b1,4}); // drain
    vt.push_back('{2'b00,1'b1,1'b1,32'hF0,  2'b11,1'b0, 1'b0,2'b10,1'b1,2'b01,1'b1,3});
    vt.push_back('{2'b00,1'b1,1'b1,32'hF1,  2'b11,1'b0, 1'b0,2'b10,1'b1,2'b10,1'b1,2});
    vt.push_back('{2'b00,1'b1,1'b1,32'hF0,  2'b11,1'b0, 1'b0,2'b10,1'b1,2'b01,1'b1,1});
    vt.push_back('{2'b00,1'b1,1'b0,32'h0,   2'b11,1'b0, 1'b0,2'b10,1'b1,2'b00,1'b0,0});

    foreach (vt[i]) begin
      step(vt[i].rv, vt[i].mr, vt[i].mv, vt[i].md, vt[i].rrdy, vt[i].fl);
      chk($sformatf("v%0d mem_req_valid", i), {31'b0, mem_req_valid}, {31'b0, vt[i].emv});
      chk($sformatf("v%0d req_ready", i), {30'b0, req_ready}, {30'b0, vt[i].erdy});
      chk($sformatf("v%0d resp_valid", i), {30'b0, resp_valid}, {30'b0, vt[i].erv});
      chk($sformatf("v%0d mem_resp_ready", i), {31'b0, mem_resp_ready}, {31'b0, vt[i].emrr});
      chk($sformatf("v%0d cnt", i), 32'(dut.cnt), 32'(vt[i].ecnt));
      if (vt[i].emv) chk($sformatf("v%0d mem_req_data", i), mem_req_data, req_data[vt[i].egr]);
      if (vt[i].erv != 2'b00) chk($sformatf("v%0d resp_data", i), resp_data, vt[i].md);
    end

    // Flush with three outstanding, one new request behind them.
    step(2'b11, 1'b1, 1'b0, 32'h0, 2'b11, 1'b0);
    step(2'b11, 1'b1, 1'b0, 32'h0, 2'b11, 1'b0);
    step(2'b11, 1'b1, 1'b0, 32'h0, 2'b11, 1'b0);
    step(2'b00, 1'b1, 1'b0, 32'h0, 2'b11, 1'b1);
    chk("flush cnt before", 32'(dut.cnt), 32'd3);
    step(2'b01, 1'b1, 1'b1, 32'h11, 2'b00, 1'b0);
    chk("flush new req issued", {31'b0, mem_req_valid}, 32'd1);
    chk("flush drop1 resp_valid", {30'b0, resp_valid}, 32'd0);
    chk("flush drop1 mem_resp_ready", {31'b0, mem_resp_ready}, 32'd1);
    step(2'b00, 1'b1, 1'b1, 32'h22, 2'b00, 1'b0);
    chk("flush drop2 resp_valid", {30'b0, resp_valid}, 32'd0);
    chk("flush drop2 mem_resp_ready", {31'b0, mem_resp_ready}, 32'd1);
    step(2'b00, 1'b1, 1'b1, 32'h33, 2'b00, 1'b0);
    chk("flush drop3 resp_valid", {30'b0, resp_valid}, 32'd0);
    chk("flush drop3 mem_resp_ready", {31'b0, mem_resp_ready}, 32'd1);
    step(2'b00, 1'b1, 1'b1, 32'h44, 2'b11, 1'b0);
    chk("post-flush resp_valid", {30'b0, resp_valid}, 32'd1);
    chk("post-flush resp_data", resp_data, 32'h44);
    // Pop in the same cycle as flush: routed by the pre-flush kill bit.
    step(2'b10, 1'b1, 1'b0, 32'h0, 2'b11, 1'b0);
    step(2'b00, 1'b1, 1'b1, 32'h55, 2'b11, 1'b1);
    chk("pop+flush resp_valid", {30'b0, resp_valid}, 32'd2);
    chk("pop+flush resp_data", resp_data, 32'h55);
    // Push in the same cycle as flush: that response is dropped.
    step(2'b01, 1'b1, 1'b0, 32'h0, 2'b11, 1'b1);
    chk("push+flush mem_req_valid", {31'b0, mem_req_valid}, 32'd1);
    step(2'b00, 1'b1, 1'b1, 32'h66, 2'b11, 1'b0);
    chk("push+flush resp_valid", {30'b0, resp_valid}, 32'd0);
    chk("push+flush mem_resp_ready", {31'b0, mem_resp_ready}, 32'd1);
    step(2'b00, 1'b1, 1'b0, 32'h0, 2'b11, 1'b0);
    chk("flush end cnt", 32'(dut.cnt), 32'd0);
    chk("flush end mem_resp_ready", {31'b0, mem_resp_ready}, 32'd0);

    // Reset with two outstanding, lock held on requester 1 and rr_ptr at 1.
    step(2'b10, 1'b1, 1'b0, 32'h0, 2'b11, 1'b0);
    step(2'b01, 1'b1, 1'b0, 32'h0, 2'b11, 1'b0);
    step(2'b10, 1'b0, 1'b0, 32'h0, 2'b11, 1'b0);
    chk("pre-reset cnt", 32'(dut.cnt), 32'd2);
    @(negedge clk);
    rst_n = 1'b0; req_valid = 2'b11; mem_req_ready = 1'b1; stall_prev = 1'b0;
    #1;
    chk("mid reset req_ready", {30'b0, req_ready}, 32'd0);
    chk("mid reset mem_req_valid", {31'b0, mem_req_valid}, 32'd0);
    chk("mid reset mem_resp_ready", {31'b0, mem_resp_ready}, 32'd0);
    chk("mid reset resp_valid", {30'b0, resp_valid}, 32'd0);
    chk("mid reset cnt", 32'(dut.cnt), 32'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("after reset req_ready", {30'b0, req_ready}, 32'd1);
    chk("after reset mem_req_data", mem_req_data, 32'h100);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
